regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with per-register scoreboard for the

---
 rtl/regfile_mp_sb_pkg.sv | 12 +
 rtl/regfile_bypass_mux.sv | 40 ++++
 rtl/regfile_mp_sb.sv | 139 +++++++++++++
 tb/tb_regfile_mp_sb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the integer register file: data width, register count,
// index width and the register index type used by issue/read/write addressing.
// No logic here; latency and backpressure are not applicable.
package regfile_mp_sb_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Purpose: one read port's write-through select; highest-index matching write wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid in the same cycle as the inputs.
// Ports: rd_addr_i/rd_ok_i (address and in-range/non-x0 qualifier), arr_data_i
//        (stored value), wr_ok_i/wr_addr_i/wr_data_i (qualified write ports),
//        rd_data_o (selected data), wr_hit_o (some write targets this address).
module regfile_bypass_mux
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int AW     = RF_AW,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]       rd_addr_i,
  input  logic                rd_ok_i,
  input  logic [XLEN-1:0]     arr_data_i,
  input  logic [NWR-1:0]      wr_ok_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic [XLEN-1:0]     rd_data_o,
  output logic                wr_hit_o
);

  // The hit flag is produced even without forwarding: the busy output still needs
  // to know a writeback lands on this register this cycle.
  always_comb begin
    rd_data_o = arr_data_i;
    wr_hit_o  = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      if (rd_ok_i && wr_ok_i[p] && (wr_addr_i[p*AW +: AW] == rd_addr_i)) begin
        wr_hit_o = 1'b1;
        if (BYPASS != 0) begin
          rd_data_o = wr_data_i[p*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Purpose: NRD-read / NWR-write integer register file with a per-register pending scoreboard.
// Latency: reads and busy are combinational (same cycle); writes and pending take effect at the next edge.
// Backpressure: none; callers stall on rd_busy_o, the file never refuses a write or issue.
// Ports: clk/reset_n; rd_addr_i -> rd_data_o, rd_busy_o; wr_en_i/wr_addr_i/wr_data_i;
//        issue_en_i/issue_addr_i mark a pending producer; flush_i clears all pending;
//        pend_cnt_o is the registered number of pending registers.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_addr_i,
  input  logic                flush_i,
  output logic [AW:0]         pend_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;
  logic [NWR-1:0]   wr_ok;
  logic [NREGS-1:0] wr_dec;

  // A write to x0 is dropped entirely, so it neither stores, forwards nor clears pending.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wr_ok[p] = wr_en_i[p];
      if ((ZERO_REG != 0) && (wr_addr_i[p*AW +: AW] == '0)) begin
        wr_ok[p] = 1'b0;
      end
    end
  end

  // Later ports overwrite earlier ones, giving the highest port index priority.
  always_comb begin
    regs_d = regs_q;
    wr_dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_ok[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
          regs_d[r] = wr_data_i[p*XLEN +: XLEN];
          wr_dec[r] = 1'b1;
        end
      end
    end
  end

  // Flush beats issue beats writeback: a fresh producer supersedes the retiring one.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush_i) begin
        pend_d[r] = 1'b0;
      end else if (issue_en_i && (issue_addr_i == AW'(r)) &&
                   !((ZERO_REG != 0) && (r == 0))) begin
        pend_d[r] = 1'b1;
      end else if (wr_dec[r]) begin
        pend_d[r] = 1'b0;
      end
    end
  end

  // Count the next-state vector so the registered count matches pend_q after the edge.
  always_comb begin
    pend_cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[r]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt_o = pend_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            ra_ok;
    logic [XLEN-1:0] arr_val;
    logic            hit;

    assign ra = rd_addr_i[k*AW +: AW];

    // ra_ok excludes x0 (when hardwired) and indices beyond the implemented registers.
    if (NREGS < (1 << AW)) begin : g_rng
      assign ra_ok = ({1'b0, ra} < (AW+1)'(NREGS)) && !((ZERO_REG != 0) && (ra == '0));
    end else begin : g_full
      assign ra_ok = !((ZERO_REG != 0) && (ra == '0));
    end

    assign arr_val = ra_ok ? regs_q[ra] : '0;

    regfile_bypass_mux #(
      .XLEN   (XLEN),
      .AW     (AW),
      .NWR    (NWR),
      .BYPASS (BYPASS)
    ) u_byp (
      .rd_addr_i  (ra),
      .rd_ok_i    (ra_ok),
      .arr_data_i (arr_val),
      .wr_ok_i    (wr_ok),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .rd_data_o  (rd_data_o[k*XLEN +: XLEN]),
      .wr_hit_o   (hit)
    );

    // Busy ignores this cycle's issue (the issuer reads before its own mark) and flush.
    assign rd_busy_o[k] = ra_ok && pend_q[ra] && !hit;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Purpose: self-checking bench for regfile_mp_sb using a scoreboard queue of expectations.
// Latency: reads sampled 1 ns after inputs settle; pend_cnt_o sampled 1 ns after the edge.
// Backpressure: not applicable; stimulus is driven every cycle on the falling edge.
module tb_regfile_mp_sb;
  import regfile_mp_sb_pkg::*;

  localparam int NRD = 2;
  localparam int NWR = 2;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NRD*RF_AW-1:0]      rd_addr_i = '0;
  logic [NRD*RF_XLEN-1:0]    rd_data_o;
  logic [NRD-1:0]            rd_busy_o;
  logic [NWR-1:0]            wr_en_i = '0;
  logic [NWR*RF_AW-1:0]      wr_addr_i = '0;
  logic [NWR*RF_XLEN-1:0]    wr_data_i = '0;
  logic                      issue_en_i = 1'b0;
  logic [RF_AW-1:0]          issue_addr_i = '0;
  logic                      flush_i = 1'b0;
  logic [RF_AW:0]            pend_cnt_o;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  logic [31:0] m_regs [32];
  logic        m_pend [32];

  regfile_mp_sb dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_busy_o    (rd_busy_o),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .issue_en_i   (issue_en_i),
    .issue_addr_i (issue_addr_i),
    .flush_i      (flush_i),
    .pend_cnt_o   (pend_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", obs, 32'hFFFF_FFFF ^ obs);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  function automatic logic m_hit(input reg_idx_t a);
    logic h = 1'b0;
    if (wr_en_i[0] && wr_addr_i[0 +: RF_AW] == a) h = 1'b1;
    if (wr_en_i[1] && wr_addr_i[RF_AW +: RF_AW] == a) h = 1'b1;
    return h && (a != 0);
  endfunction

  function automatic logic [31:0] m_read(input reg_idx_t a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_regs[a];
    if (wr_en_i[0] && wr_addr_i[0 +: RF_AW] == a) v = wr_data_i[0 +: 32];
    if (wr_en_i[1] && wr_addr_i[RF_AW +: RF_AW] == a) v = wr_data_i[32 +: 32];
    return v;
  endfunction

  function automatic logic m_busy(input reg_idx_t a);
    return (a != 0) && m_pend[a] && !m_hit(a);
  endfunction

  task automatic m_update();
    reg_idx_t a;
    for (int p = 0; p < NWR; p++) begin
      a = wr_addr_i[p*RF_AW +: RF_AW];
      if (wr_en_i[p] && a != 0) begin
        m_regs[a] = wr_data_i[p*32 +: 32];
        m_pend[a] = 1'b0;
      end
    end
    if (issue_en_i && issue_addr_i != 0) m_pend[issue_addr_i] = 1'b1;
    if (flush_i) for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
  endtask

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  // One cycle: drive, check combinational reads, clock, check the registered count.
  // lit_rd0 / lit_cnt add literal expectations on top of the model (-1 / lit_en=0 to skip).
  task automatic step(input reg_idx_t ra0, input reg_idx_t ra1,
                      input logic we0, input reg_idx_t wa0, input logic [31:0] wd0,
                      input logic we1, input reg_idx_t wa1, input logic [31:0] wd1,
                      input logic iss, input reg_idx_t ia, input logic fl,
                      input logic lit_en, input logic [31:0] lit_rd0, input int lit_cnt);
    @(negedge clk);
    rd_addr_i    = {ra1, ra0};
    wr_en_i      = {we1, we0};
    wr_addr_i    = {wa1, wa0};
    wr_data_i    = {wd1, wd0};
    issue_en_i   = iss;
    issue_addr_i = ia;
    flush_i      = fl;
    sb_push("rd0", m_read(ra0));
    sb_push("rd1", m_read(ra1));
    sb_push("busy0", 32'(m_busy(ra0)));
    sb_push("busy1", 32'(m_busy(ra1)));
    if (lit_en) sb_push("rd0_lit", lit_rd0);
    #1;
    sb_pop_check(rd_data_o[0 +: 32]);
    sb_pop_check(rd_data_o[32 +: 32]);
    sb_pop_check(32'(rd_busy_o[0]));
    sb_pop_check(32'(rd_busy_o[1]));
    if (lit_en) sb_pop_check(rd_data_o[0 +: 32]);
    @(posedge clk);
    m_update();
    sb_push("pend_cnt", 32'(m_count()));
    if (lit_cnt >= 0) sb_push("pend_cnt_lit", 32'(lit_cnt));
    #1;
    sb_pop_check(32'(pend_cnt_o));
    if (lit_cnt >= 0) sb_pop_check(32'(pend_cnt_o));
  endtask

  task automatic rd_only(input reg_idx_t ra0, input reg_idx_t ra1,
                         input logic lit_en, input logic [31:0] lit_rd0, input int lit_cnt);
    step(ra0, ra1, 0, 0, 0, 0, 0, 0, 0, 0, 0, lit_en, lit_rd0, lit_cnt);
  endtask

  initial begin
    m_clear();
    // Reset state while held in reset.
    rd_addr_i = {5'd7, 5'd5};
    #2;
    check_val("rst_rd0", rd_data_o[0 +: 32], 32'h0);
    check_val("rst_busy", 32'(rd_busy_o), 32'h0);
    check_val("rst_cnt", 32'(pend_cnt_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Write x5 via port 0, forwarded in the same cycle and stored for the next.
    step(5, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    rd_only(5, 5, 1, 32'hDEADBEEF, 0);
    // x0 ignores writes.
    step(0, 5, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    rd_only(0, 0, 1, 32'h0, 0);
    // Bypass through port 1.
    step(7, 7, 0, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 1, 32'hA5A5A5A5, 0);
    // Same-address collision: port 1 wins.
    step(3, 3, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 0, 1, 32'h22, 0);
    rd_only(3, 7, 1, 32'h22, 0);

    // Scoreboard: issue, writeback+reissue, writeback alone.
    step(9, 9, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1);
    rd_only(9, 3, 0, 0, 1);
    step(9, 9, 1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 1, 32'h99, 1);
    rd_only(9, 9, 1, 32'h99, 1);
    step(9, 9, 0, 0, 0, 1, 9, 32'h77, 0, 0, 0, 1, 32'h77, 0);

    // Flush overrides a same-cycle issue.
    step(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 2);
    step(1, 3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 3);
    step(1, 4, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
    rd_only(4, 1, 0, 0, 0);
    // Issue to x0 never marks it pending.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(reg_idx_t'($urandom_range(0, 31)), reg_idx_t'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 3) != 0), reg_idx_t'($urandom_range(0, 31)),
           1'($urandom_range(0, 31) == 0), 0, 0, -1);
    end

    // Mid-cycle asynchronous reset after state has been built up.
    step(5, 7, 1, 5, 32'hCAFEF00D, 1, 7, 32'h12345678, 1, 11, 0, 0, 0, -1);
    @(negedge clk);
    wr_en_i    = '0;
    issue_en_i = 1'b0;
    flush_i    = 1'b0;
    rd_addr_i  = {5'd7, 5'd5};
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_rd0", rd_data_o[0 +: 32], 32'h0);
    check_val("arst_rd1", rd_data_o[32 +: 32], 32'h0);
    check_val("arst_busy", 32'(rd_busy_o), 32'h0);
    check_val("arst_cnt", 32'(pend_cnt_o), 32'h0);
    m_clear();
    @(negedge clk);
    reset_n = 1'b1;
    rd_only(5, 11, 1, 32'h0, 0);
    step(12, 12, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 1);
    rd_only(12, 5, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
